// File: rtl/i2s_pkg.sv
// Shared definitions for the stereo serial audio transmitter: mode encodings
// and the slot-position to sample-bit mapping used by the dout mux.
package i2s_pkg;

    localparam logic [1:0] I2S_MODE_I2S = 2'b00;
    localparam logic [1:0] I2S_MODE_LJ  = 2'b01;
    localparam logic [1:0] I2S_MODE_RJ  = 2'b10;

    // Sentinel results of slot_bit_idx: drive a zero, or drive the carried bit.
    localparam int I2S_IDX_ZERO  = -1;
    localparam int I2S_IDX_CARRY = -2;

    // Sample bit index for slot position p; mode 2'b11 falls through to I2S.
    function automatic int slot_bit_idx(input logic [1:0] mode, input int p,
                                        input int data_w, input int slot_w);
        int idx;
        idx = I2S_IDX_ZERO;
        case (mode)
            I2S_MODE_LJ: if (p < data_w) idx = data_w - 1 - p;
            I2S_MODE_RJ: if (p >= slot_w - data_w) idx = slot_w - 1 - p;
            default: begin
                if (p == 0) idx = I2S_IDX_CARRY;
                else if (p <= data_w) idx = data_w - p;
            end
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// MCLK/SCLK dividers and frame bit counter; o_fall marks the cycle before sclk
// drops, o_wrap the falling strobe on which the bit counter returns to 0.
module i2s_clkgen #(
    parameter int SLOT_W    = 32,
    parameter int SCLK_HALF = 8,
    parameter int MCLK_HALF = 2,
    localparam int CNT_W    = $clog2(2 * SLOT_W)
) (
    input  logic             clk48m,
    input  logic             rst,
    output logic             o_mclk,
    output logic             o_sclk,
    output logic             o_lrclk,
    output logic             o_fall,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_bit_cnt_next
);

    localparam int MC_W = $clog2(MCLK_HALF + 1);
    localparam int SC_W = $clog2(SCLK_HALF + 1);
    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(MCLK_HALF - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT_W - 1);

    logic [MC_W-1:0]  r_mcnt;
    logic [SC_W-1:0]  r_scnt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_mclk;
    logic             r_sclk;
    logic             r_lrclk;
    logic             w_fall;
    logic             w_last_bit;
    logic [CNT_W-1:0] w_bit_cnt_next;

    assign w_fall         = r_sclk && (r_scnt == SC_LAST);
    assign w_last_bit     = (r_bit_cnt == BIT_LAST);
    assign w_bit_cnt_next = w_last_bit ? '0 : r_bit_cnt + 1'b1;

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            r_mcnt    <= '0;
            r_scnt    <= '0;
            r_bit_cnt <= '0;
            r_mclk    <= 1'b0;
            r_sclk    <= 1'b0;
            r_lrclk   <= 1'b0;
        end else begin
            if (r_mcnt == MC_LAST) begin
                r_mcnt <= '0;
                r_mclk <= ~r_mclk;
            end else begin
                r_mcnt <= r_mcnt + 1'b1;
            end
            if (r_scnt == SC_LAST) begin
                r_scnt <= '0;
                r_sclk <= ~r_sclk;
            end else begin
                r_scnt <= r_scnt + 1'b1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_cnt_next;
                r_lrclk   <= (w_bit_cnt_next >= CNT_W'(SLOT_W));
            end
        end
    end

    assign o_mclk         = r_mclk;
    assign o_sclk         = r_sclk;
    assign o_lrclk        = r_lrclk;
    assign o_fall         = w_fall;
    assign o_wrap         = w_fall && w_last_bit;
    assign o_bit_cnt_next = w_bit_cnt_next;

endmodule

// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left- / right-justified transmitter with a one-entry holding buffer.
// Optional macro I2S_TX_UNDERRUN_EN adds the underrun pulse output.
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int SLOT_W    = 32,
    parameter int SCLK_HALF = 8,
    parameter int MCLK_HALF = 2
) (
    input  logic              clk48m,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              mclk,
    output logic              sclk,
    output logic              lrclk,
    output logic              dout,
    output logic              frame_start
`ifdef I2S_TX_UNDERRUN_EN
    ,
    output logic              underrun
`endif
);

    localparam int CNT_W = $clog2(2 * SLOT_W);

    logic              w_fall;
    logic              w_wrap;
    logic [CNT_W-1:0]  w_bit_cnt_next;
    logic              w_accept;
    logic              w_full_next;
    logic [DATA_W-1:0] w_load_left;
    logic [DATA_W-1:0] w_load_right;
    logic [1:0]        w_mode_eff;
    logic              w_right_slot;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_shift;
    int                w_pos;
    int                w_idx;
    logic              w_bit;
    logic              w_carry_next;

    logic              r_ready;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_left;
    logic [DATA_W-1:0] r_hold_right;
    logic [DATA_W-1:0] r_act_left;
    logic [DATA_W-1:0] r_act_right;
    logic [1:0]        r_mode;
    logic              r_dout;
    logic              r_carry;

    i2s_clkgen #(
        .SLOT_W   (SLOT_W),
        .SCLK_HALF(SCLK_HALF),
        .MCLK_HALF(MCLK_HALF)
    ) u_clkgen (
        .clk48m        (clk48m),
        .rst           (rst),
        .o_mclk        (mclk),
        .o_sclk        (sclk),
        .o_lrclk       (lrclk),
        .o_fall        (w_fall),
        .o_wrap        (w_wrap),
        .o_bit_cnt_next(w_bit_cnt_next)
    );

    // Load decision uses the pre-edge buffer; a same-cycle accept waits a frame.
    assign w_accept     = s_valid && r_ready;
    assign w_full_next  = w_accept || (r_hold_full && !w_wrap);
    assign w_load_left  = r_hold_full ? r_hold_left  : '0;
    assign w_load_right = r_hold_full ? r_hold_right : '0;

    // On the wrap strobe the first bit comes from the words being loaded.
    assign w_mode_eff   = w_wrap ? mode : r_mode;
    assign w_right_slot = (w_bit_cnt_next >= CNT_W'(SLOT_W));

    always_comb begin
        w_data  = '0;
        w_shift = '0;
        w_pos   = 0;
        w_idx   = I2S_IDX_ZERO;
        w_bit   = 1'b0;
        if (w_right_slot) begin
            w_data = w_wrap ? w_load_right : r_act_right;
            w_pos  = int'(w_bit_cnt_next) - SLOT_W;
        end else begin
            w_data = w_wrap ? w_load_left : r_act_left;
            w_pos  = int'(w_bit_cnt_next);
        end
        w_idx = slot_bit_idx(w_mode_eff, w_pos, DATA_W, SLOT_W);
        if (w_idx == I2S_IDX_CARRY) begin
            w_bit = r_carry;
        end else if (w_idx >= 0) begin
            w_shift = w_data >> w_idx;
            w_bit   = w_shift[0];
        end
    end

    // The delayed I2S stream spills a slot's LSB into the next slot only when full width.
    assign w_carry_next = (DATA_W == SLOT_W) ? w_data[0] : 1'b0;

    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            r_ready      <= 1'b0;
            r_hold_full  <= 1'b0;
            r_hold_left  <= '0;
            r_hold_right <= '0;
            r_act_left   <= '0;
            r_act_right  <= '0;
            r_mode       <= I2S_MODE_I2S;
            r_dout       <= 1'b0;
            r_carry      <= 1'b0;
        end else begin
            r_ready     <= !w_full_next;
            r_hold_full <= w_full_next;
            if (w_accept) begin
                r_hold_left  <= s_left;
                r_hold_right <= s_right;
            end
            if (w_wrap) begin
                r_act_left  <= w_load_left;
                r_act_right <= w_load_right;
                r_mode      <= mode;
            end
            if (w_fall) begin
                r_dout  <= w_bit;
                r_carry <= w_carry_next;
            end
        end
    end

    assign s_ready     = r_ready;
    assign dout        = r_dout;
    assign frame_start = w_wrap;
`ifdef I2S_TX_UNDERRUN_EN
    assign underrun    = w_wrap && !r_hold_full;
`endif

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Bench for i2s_stereo_tx: directed samples, an expected-frame queue filled at
// each frame load, and a serial monitor that reassembles dout/lrclk per frame.
module tb_i2s_stereo_tx;

    localparam logic [1:0]  M_I2S  = 2'b00;
    localparam logic [1:0]  M_LJ   = 2'b01;
    localparam logic [1:0]  M_RJ   = 2'b10;
    localparam logic [23:0] A_L    = 24'hABCDEF;
    localparam logic [23:0] A_R    = 24'h123456;
    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    logic        clk48m  = 1'b0;
    logic        rst     = 1'b0;
    logic [1:0]  mode    = 2'b00;
    logic        s_valid = 1'b0;
    logic [23:0] s_left  = '0;
    logic [23:0] s_right = '0;
    logic        s_ready;
    logic        mclk;
    logic        sclk;
    logic        lrclk;
    logic        dout;
    logic        frame_start;
`ifdef I2S_TX_UNDERRUN_EN
    logic        underrun;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] pend_q[$];

    i2s_stereo_tx #(
        .DATA_W   (24),
        .SLOT_W   (32),
        .SCLK_HALF(8),
        .MCLK_HALF(2)
    ) dut (
        .clk48m     (clk48m),
        .rst        (rst),
        .mode       (mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .mclk       (mclk),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .dout       (dout),
        .frame_start(frame_start)
`ifdef I2S_TX_UNDERRUN_EN
        ,
        .underrun   (underrun)
`endif
    );

    always #5 clk48m = ~clk48m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic wait_fs();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2100 && !ok; i++) begin
            @(negedge clk48m);
            if (frame_start) ok = 1'b1;
        end
        if (!ok) fail_now("frame_start_timeout");
    endtask

    // Offer one pair after a frame load (or in the load cycle itself).
    task automatic offer(input logic [1:0] m, input logic [23:0] l, input logic [23:0] r,
                         input logic [63:0] exp, input bit in_wrap);
        bit got;
        got = 1'b0;
        wait_fs();
        if (!in_wrap) begin
            @(posedge clk48m);
            #1;
        end
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        for (int i = 0; i < 2100 && !got; i++) begin
            if (s_ready) got = 1'b1;
            @(posedge clk48m);
            #1;
        end
        s_valid = 1'b0;
        mode    = m;
        if (got) pend_q.push_back(exp);
        else fail_now("accept_timeout");
    endtask

    // s_valid held high with incrementing pairs: one accept per frame, 8 frames.
    task automatic stream8();
        int acc;
        int sent;
        int checked;
        bit rdy;
        bit done;
        acc = 0;
        sent = 0;
        checked = 0;
        done = 1'b0;
        wait_fs();
        s_valid = 1'b1;
        s_left  = 24'hC0FFE0;
        s_right = 24'h0A0B00;
        for (int cyc = 0; cyc < 10000 && !done; cyc++) begin
            if (cyc > 0 && frame_start) begin
                check("accepts_per_frame", 64'(acc), 64'd1);
                acc = 0;
                checked++;
                if (checked == 8) done = 1'b1;
            end
            if (!done) begin
                rdy = s_ready;
                @(posedge clk48m);
                #1;
                if (cyc == 0) mode = M_LJ;
                if (rdy && s_valid) begin
                    pend_q.push_back({s_left, 8'h00, s_right, 8'h00});
                    acc++;
                    sent++;
                    if (sent == 8) begin
                        s_valid = 1'b0;
                    end else begin
                        s_left  = s_left + 24'd1;
                        s_right = s_right + 24'd1;
                    end
                end
                @(negedge clk48m);
            end
        end
        if (!done) fail_now("stream_timeout");
    endtask

    // Each frame load fixes what the following 64 bits must carry.
    initial begin
        forever begin
            @(negedge clk48m);
            if (frame_start && !rst) begin
`ifdef I2S_TX_UNDERRUN_EN
                check("underrun_pulse", 64'(underrun), 64'(pend_q.size() == 0));
`endif
                if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
                else exp_q.push_back(64'd0);
            end
        end
    end

    // Serial monitor: sample dout/lrclk on each sclk rise, compare a whole frame.
    initial begin
        logic [63:0] rx_d;
        logic [63:0] rx_lr;
        logic [63:0] e;
        int          pos;
        bit          mon_on;
        logic        prev_sclk;
        rx_d = '0;
        rx_lr = '0;
        pos = 0;
        mon_on = 1'b0;
        prev_sclk = 1'b0;
        forever begin
            @(negedge clk48m);
            if (rst) begin
                mon_on = 1'b0;
                prev_sclk = 1'b0;
            end else begin
                if (mon_on && sclk && !prev_sclk) begin
                    rx_d[63-pos]  = dout;
                    rx_lr[63-pos] = lrclk;
                    pos++;
                    if (pos == 64) begin
                        mon_on = 1'b0;
                        if (exp_q.size() == 0) begin
                            fail_now("frame_without_expectation");
                        end else begin
                            e = exp_q.pop_front();
                            check("frame_dout", rx_d, e);
                            check("frame_lrclk", rx_lr, LR_EXP);
                        end
                    end
                end
                if (frame_start) begin
                    mon_on = 1'b1;
                    pos = 0;
                end
                prev_sclk = sclk;
            end
        end
    end

    initial begin
        logic [15:0] mw;
        logic [15:0] sw;
        int          falls;
        int          cnt;
        bit          seen;
        logic        prev;
        mw = '0;
        sw = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk48m);
        check("reset_ready", 64'(s_ready), 64'd0);
        check("reset_outputs", 64'({mclk, sclk, lrclk, dout, frame_start}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk48m);
            mw[15-i] = mclk;
            sw[15-i] = sclk;
            if (i == 0) check("ready_after_release", 64'(s_ready), 64'd1);
        end
        check("mclk_wave", 64'(mw), 64'h6666);
        check("sclk_wave", 64'(sw), 64'h01FE);

        offer(M_LJ, A_L, A_R, {A_L, 8'h00, A_R, 8'h00}, 1'b1);
        offer(M_I2S, A_L, A_R, {1'b0, A_L, 7'h00, 1'b0, A_R, 7'h00}, 1'b0);
        offer(M_RJ, A_L, A_R, {8'h00, A_L, 8'h00, A_R}, 1'b0);
        stream8();

        // Reset in the middle of a frame, at bit_cnt 40.
        wait_fs();
        falls = 0;
        prev = sclk;
        for (int i = 0; i < 1000 && falls < 41; i++) begin
            @(negedge clk48m);
            if (prev && !sclk) falls++;
            prev = sclk;
        end
        if (falls < 41) fail_now("bit40_timeout");
        rst = 1'b1;
        @(posedge clk48m);
        #1;
        check("midframe_reset_outputs",
              64'({mclk, sclk, lrclk, dout, frame_start, s_ready}), 64'd0);
        exp_q.delete();
        pend_q.delete();
        repeat (4) @(negedge clk48m);
        rst = 1'b0;
        cnt = 0;
        seen = 1'b0;
        for (int i = 1; i <= 2100 && !seen; i++) begin
            @(negedge clk48m);
            if (frame_start) begin
                seen = 1'b1;
                cnt = i;
            end
        end
        check("first_frame_start_after_reset", 64'(cnt), 64'd1023);

        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk48m);
        check("expected_queue_drained", 64'(exp_q.size()), 64'd0);
        check("pending_queue_empty", 64'(pend_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
